rvx_external_interrupt_controller: RTL and testbench

Memory-mapped controller that collects up to NUM_SOURCES asynchronous peripheral interrupt lines and produces the single irq_external line that feeds the core's mip.MEIP bit. Sources are fixed-priority: lowest index wins. Software services sources through a claim/complete handshake, with one claim outstanding at a time. The block sits on the RVX system bus next to the timer and the other peripherals.

---
 rtl/rvx_external_interrupt_controller_pkg.sv | 23 ++
 rtl/rvx_irq_input_sync.sv | 30 +++
 rtl/rvx_external_interrupt_controller.sv | 138 +++++++++++++
 tb/tb_rvx_external_interrupt_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_external_interrupt_controller_pkg.sv
// Shared constants for the RVX external interrupt controller.
// Contents: register byte offsets, claim FSM states, the "no interrupt" ID and a write-strobe helper.
package rvx_external_interrupt_controller_pkg;

    localparam logic [4:0] OFFSET_PENDING = 5'h00;
    localparam logic [4:0] OFFSET_ENABLE  = 5'h04;
    localparam logic [4:0] OFFSET_EDGE    = 5'h08;
    localparam logic [4:0] OFFSET_CLAIM   = 5'h0C;
    localparam logic [4:0] OFFSET_STATUS  = 5'h10;

    localparam logic [4:0] ID_NONE = 5'd0;

    typedef enum logic {
        STATE_IDLE    = 1'b0,
        STATE_CLAIMED = 1'b1
    } state_t;

    // True when the byte lane holding bit_index is enabled in the write strobe.
    function automatic logic byte_enabled(input logic [3:0] strobe, input int bit_index);
        return strobe[2'(bit_index / 8)];
    endfunction

endpackage

// File: rtl/rvx_irq_input_sync.sv
// Brings one asynchronous interrupt line into the clock domain.
// Outputs the synchronized level and a one-cycle pulse on its rising edge.
module rvx_irq_input_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic source,
    output logic sync_2,
    output logic rise
);

    logic sync_1;
    logic prev;

    // NOTE: non-blocking assignments make each flop capture its predecessor's pre-edge value,
    // which is what turns three statements into a shift chain rather than one wire.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= source;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign rise = sync_2 & ~prev;

endmodule

// File: rtl/rvx_external_interrupt_controller.sv
// Fixed-priority external interrupt controller (lowest source index wins).
// Bus-mapped registers and a single-outstanding claim/complete handshake drive irq_external.
module rvx_external_interrupt_controller #(
    parameter int NUM_SOURCES = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4:0]             rw_address,
    input  logic                   read_request,
    output logic                   read_response,
    output logic [31:0]            read_data,
    input  logic                   write_request,
    input  logic [31:0]            write_data,
    input  logic [3:0]             write_strobe,
    output logic                   write_response,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    output logic                   irq_external
);

    import rvx_external_interrupt_controller_pkg::*;

    logic [NUM_SOURCES-1:0] sync_2;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] enable;
    logic [NUM_SOURCES-1:0] edge_mode;
    logic [NUM_SOURCES-1:0] edge_latch;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] enable_next;
    logic [NUM_SOURCES-1:0] edge_mode_next;
    logic [NUM_SOURCES-1:0] edge_latch_next;
    logic [NUM_SOURCES-1:0] claim_clear;

    state_t      state;
    logic [4:0]  in_service;
    logic [4:0]  candidate;
    logic [4:0]  offset;
    logic        read_only;
    logic        claim_grant;
    logic        complete;
    logic [31:0] read_value;
    logic        unused_bits;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_sync
        rvx_irq_input_sync u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .source  (irq_sources[g]),
            .sync_2  (sync_2[g]),
            .rise    (rise[g])
        );
    end

    assign offset      = {rw_address[4:2], 2'b00};
    assign unused_bits = ^{rw_address[1:0], write_data};

    // A read colliding with a write answers 0 and must not claim anything.
    assign read_only = read_request & ~write_request;

    assign pending = (edge_mode & edge_latch) | (~edge_mode & sync_2);

    // NOTE: every variable driven here gets a value before any conditional, so no latch is inferred.
    always_comb begin
        candidate = ID_NONE;
        for (int n = NUM_SOURCES - 1; n >= 0; n--) begin
            if (pending[n] && enable[n]) candidate = 5'(n + 1);
        end
    end

    assign claim_grant = read_only && (offset == OFFSET_CLAIM) &&
                         (state == STATE_IDLE) && (candidate != ID_NONE);
    assign complete    = write_request && (offset == OFFSET_CLAIM) && write_strobe[0] &&
                         (state == STATE_CLAIMED) && (write_data[4:0] == in_service);

    always_comb begin
        enable_next    = enable;
        edge_mode_next = edge_mode;
        claim_clear    = '0;
        for (int n = 0; n < NUM_SOURCES; n++) begin
            if (write_request && byte_enabled(write_strobe, n)) begin
                if (offset == OFFSET_ENABLE) enable_next[n]    = write_data[n];
                if (offset == OFFSET_EDGE)   edge_mode_next[n] = write_data[n];
            end
            claim_clear[n] = claim_grant && (candidate == 5'(n + 1));
        end
        // A fresh rise outranks a same-cycle claim; leaving edge mode discards the latch.
        edge_latch_next = edge_mode_next & (rise | (edge_latch & ~claim_clear));
    end

    always_comb begin
        read_value = '0;
        case (offset)
            OFFSET_PENDING: read_value = 32'(pending);
            OFFSET_ENABLE:  read_value = 32'(enable);
            OFFSET_EDGE:    read_value = 32'(edge_mode);
            OFFSET_CLAIM:   read_value = {27'd0, claim_grant ? candidate : ID_NONE};
            OFFSET_STATUS:  read_value = {19'd0, in_service, 7'd0, state == STATE_CLAIMED};
            default:        read_value = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= STATE_IDLE;
            in_service     <= ID_NONE;
            enable         <= '0;
            edge_mode      <= '0;
            edge_latch     <= '0;
            read_response  <= 1'b0;
            read_data      <= '0;
            write_response <= 1'b0;
            irq_external   <= 1'b0;
        end else begin
            enable         <= enable_next;
            edge_mode      <= edge_mode_next;
            edge_latch     <= edge_latch_next;
            read_response  <= read_request;
            read_data      <= read_only ? read_value : 32'd0;
            write_response <= write_request;
            irq_external   <= (state == STATE_IDLE) && (candidate != ID_NONE);
            case (state)
                STATE_IDLE: begin
                    if (claim_grant) begin
                        state      <= STATE_CLAIMED;
                        in_service <= candidate;
                    end
                end
                STATE_CLAIMED: begin
                    if (complete) begin
                        state      <= STATE_IDLE;
                        in_service <= ID_NONE;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvx_external_interrupt_controller.sv
// Bench for rvx_external_interrupt_controller: directed scenarios plus random traffic,
// with every output compared each cycle against a register-level reference model.
module tb_rvx_external_interrupt_controller;

    localparam int N = 16;
    localparam logic [31:0] SRC_MASK = (32'd1 << N) - 32'd1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    rw_address = '0;
    logic          read_request = 1'b0;
    logic          read_response;
    logic [31:0]   read_data;
    logic          write_request = 1'b0;
    logic [31:0]   write_data = '0;
    logic [3:0]    write_strobe = '0;
    logic          write_response;
    logic [N-1:0]  irq_sources = '0;
    logic          irq_external;

    always #5 clock = ~clock;

    rvx_external_interrupt_controller #(.NUM_SOURCES(N)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rw_address     (rw_address),
        .read_request   (read_request),
        .read_response  (read_response),
        .read_data      (read_data),
        .write_request  (write_request),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_response (write_response),
        .irq_sources    (irq_sources),
        .irq_external   (irq_external)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: sampled input history plus the software-visible register state.
    logic [31:0] hist [0:2];
    logic [31:0] m_enable = '0, m_edge = '0, m_latch = '0, m_rdata = '0;
    logic [4:0]  m_in_service = '0;
    logic        m_claimed = 1'b0, m_irq = 1'b0, m_rresp = 1'b0, m_wresp = 1'b0;

    initial for (int k = 0; k < 3; k++) hist[k] = '0;

    function automatic int lowest_id(input logic [31:0] bits);
        for (int n = 0; n < N; n++) if (bits[n]) return n + 1;
        return 0;
    endfunction

    always @(posedge clock) begin : model_update
        logic [31:0] s2, rise, pend, clr, new_edge, mask;
        int id;
        int word;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
            m_enable = '0; m_edge = '0; m_latch = '0; m_rdata = '0;
            m_in_service = '0; m_claimed = 1'b0; m_irq = 1'b0;
            m_rresp = 1'b0; m_wresp = 1'b0;
        end else begin
            s2   = hist[1];
            rise = hist[1] & ~hist[2];
            pend = ((m_edge & m_latch) | (~m_edge & s2)) & SRC_MASK;
            id   = lowest_id(pend & m_enable);
            m_irq   = !m_claimed && (id != 0);
            m_rresp = read_request;
            m_wresp = write_request;
            m_rdata = '0;
            word = int'(rw_address) / 4;
            clr = '0;
            new_edge = m_edge;
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{write_strobe[b]}};
            mask = mask & SRC_MASK;
            if (write_request) begin
                case (word)
                    1: m_enable = (m_enable & ~mask) | (write_data & mask);
                    2: new_edge = (m_edge & ~mask) | (write_data & mask);
                    3: if (write_strobe[0] && m_claimed && write_data[4:0] == m_in_service) begin
                           m_claimed = 1'b0;
                           m_in_service = '0;
                       end
                    default: ;
                endcase
            end else if (read_request) begin
                case (word)
                    0: m_rdata = pend;
                    1: m_rdata = m_enable;
                    2: m_rdata = m_edge;
                    3: if (!m_claimed && id != 0) begin
                           m_rdata = 32'(id);
                           m_claimed = 1'b1;
                           m_in_service = 5'(id);
                           clr = 32'd1 << (id - 1);
                       end
                    4: m_rdata = (32'(m_in_service) << 8) | 32'(m_claimed);
                    default: ;
                endcase
            end
            m_latch = new_edge & (rise | (m_latch & ~clr));
            m_edge  = new_edge;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = 32'(irq_sources);
        end
    end

    always @(negedge clock) begin
        check("model_irq_external", 32'(irq_external), 32'(m_irq));
        check("model_read_response", 32'(read_response), 32'(m_rresp));
        check("model_read_data", read_data, m_rdata);
        check("model_write_response", 32'(write_response), 32'(m_wresp));
    end

    task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
        @(negedge clock);
        rw_address = addr;
        read_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
        check("read_response_pulse", 32'(read_response), 32'd1);
        data = read_data;
    endtask

    task automatic read_expect(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        bus_read(addr, data);
        check(tag, data, expected);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] value, input logic [3:0] strobe);
        @(negedge clock);
        rw_address = addr;
        write_data = value;
        write_strobe = strobe;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        check("write_response_pulse", 32'(write_response), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] data;
        logic [N-1:0] flips;
        int op;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check("irq_after_reset", 32'(irq_external), 32'd0);
        read_expect("reset_pending", 5'h00, 32'd0);
        read_expect("reset_enable",  5'h04, 32'd0);
        read_expect("reset_edge",    5'h08, 32'd0);
        read_expect("reset_claim",   5'h0C, 32'd0);
        read_expect("reset_status",  5'h10, 32'd0);

        // Edge source 0: one-cycle pulse, latency, claim and complete.
        bus_write(5'h08, 32'h1, 4'hF);
        bus_write(5'h04, 32'h1, 4'hF);
        @(negedge clock); irq_sources[0] = 1'b1;
        @(negedge clock); irq_sources[0] = 1'b0;
        @(negedge clock);
        @(negedge clock); check("edge_irq_before_e3", 32'(irq_external), 32'd0);
        @(negedge clock); check("edge_irq_after_e3", 32'(irq_external), 32'd1);
        read_expect("pending_src0", 5'h00, 32'h1);
        read_expect("claim_src0", 5'h0C, 32'd1);
        @(negedge clock); check("irq_low_after_claim", 32'(irq_external), 32'd0);
        read_expect("status_claimed_src0", 5'h10, 32'h101);
        bus_write(5'h0C, 32'd1, 4'h1);
        read_expect("status_after_complete", 5'h10, 32'h0);

        // Level sources 3 and 5.
        bus_write(5'h08, 32'h0, 4'hF);
        bus_write(5'h04, 32'h28, 4'hF);
        irq_sources[3] = 1'b1;
        irq_sources[5] = 1'b1;
        repeat (4) @(negedge clock);
        check("level_irq", 32'(irq_external), 32'd1);
        read_expect("claim_level", 5'h0C, 32'd4);
        read_expect("claim_while_claimed", 5'h0C, 32'd0);
        bus_write(5'h0C, 32'd6, 4'h1);
        read_expect("status_wrong_complete", 5'h10, 32'h401);
        bus_write(5'h0C, 32'd4, 4'h1);
        read_expect("claim_level_again", 5'h0C, 32'd4);
        bus_write(5'h0C, 32'd4, 4'h1);
        irq_sources = '0;

        // Edge source 2 pending while disabled.
        bus_write(5'h04, 32'h0, 4'hF);
        bus_write(5'h08, 32'h4, 4'hF);
        irq_sources[2] = 1'b1;
        @(negedge clock); irq_sources[2] = 1'b0;
        repeat (4) @(negedge clock);
        check("masked_irq", 32'(irq_external), 32'd0);
        read_expect("pending_masked", 5'h00, 32'h4);
        bus_write(5'h04, 32'h4, 4'hF);
        @(negedge clock); check("unmasked_irq", 32'(irq_external), 32'd1);
        bus_write(5'h08, 32'h0, 4'hF);
        read_expect("pending_edge_cleared", 5'h00, 32'h0);

        // Rise on source 0 arriving in the same cycle as its claim.
        bus_write(5'h04, 32'h1, 4'hF);
        bus_write(5'h08, 32'h1, 4'hF);
        irq_sources[0] = 1'b1;
        @(negedge clock); irq_sources[0] = 1'b0;
        repeat (4) @(negedge clock);
        irq_sources[0] = 1'b1;
        @(negedge clock);
        bus_read(5'h0C, data);
        check("claim_coincident_rise", data, 32'd1);
        read_expect("pending_set_wins", 5'h00, 32'h1);
        bus_write(5'h0C, 32'd1, 4'h1);
        irq_sources[0] = 1'b0;
        read_expect("claim_relatched", 5'h0C, 32'd1);
        bus_write(5'h0C, 32'd1, 4'h1);

        // Reset during an outstanding claim, then a colliding read and write.
        bus_write(5'h08, 32'h0, 4'hF);
        bus_write(5'h04, 32'h2, 4'hF);
        irq_sources[1] = 1'b1;
        repeat (4) @(negedge clock);
        read_expect("claim_src1", 5'h0C, 32'd2);
        irq_sources[1] = 1'b0;
        reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        check("irq_after_midclaim_reset", 32'(irq_external), 32'd0);
        read_expect("status_after_reset", 5'h10, 32'h0);
        read_expect("pending_after_reset", 5'h00, 32'h0);
        @(negedge clock);
        rw_address = 5'h04;
        write_data = 32'h55;
        write_strobe = 4'hF;
        read_request = 1'b1;
        write_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
        write_request = 1'b0;
        check("collide_read_response", 32'(read_response), 32'd1);
        check("collide_read_data", read_data, 32'd0);
        check("collide_write_response", 32'(write_response), 32'd1);
        read_expect("enable_after_collide", 5'h04, 32'h55);

        // Random traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 500; it++) begin
            for (int n = 0; n < N; n++) flips[n] = ($urandom_range(0, 11) == 0);
            irq_sources = irq_sources ^ flips;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: @(negedge clock);
                3, 4:    bus_read(5'($urandom), data);
                5, 6:    bus_read(5'h0C, data);
                7:       bus_write(5'h0C, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 17))
                                                                      : 32'(m_in_service),
                                   4'($urandom));
                8:       bus_write(($urandom_range(0, 1) == 0) ? 5'h04 : 5'h08, $urandom, 4'($urandom));
                default: begin
                    @(negedge clock);
                    rw_address = 5'($urandom);
                    write_data = $urandom;
                    write_strobe = 4'($urandom);
                    read_request = 1'b1;
                    write_request = 1'b1;
                    @(negedge clock);
                    read_request = 1'b0;
                    write_request = 1'b0;
                    check("random_collide_data", read_data, 32'd0);
                end
            endcase
        end

        irq_sources = '0;
        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
